add_controller: RTL
===================

# add_controller

Sequencing FSM that sits directly upstream of the 6-bit adder datapath and drives its enx, eny, sa, sb and sy controls. On a start request it runs a fixed program on the datapath:

- load x = a + b and y = a + 3;
- accumulate x += y a programmable number of times;
- read out x + 3.

It captures that datapath result into a registered output and signals completion with a one-cycle done pulse.

## Interface
Parameters:
- CNT_W, default 4: width of the iteration count input n.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset. Synchronous, active-high.
- start  in  1  request to begin a run. Sampled only in IDLE.
- n  in  CNT_W  number of accumulate iterations. Latched when start is accepted.
- dp_result  in  6  datapath adder output. Valid during the OUT state.
- enx  out  1  datapath x-register load enable.
- eny  out  1  datapath y-register load enable.
- sa  out  1  adder A select: 1 = external a, 0 = xi.
- sb  out  1  adder B select: 1 = external b.
- sy  out  1  adder B select when sb = 0: 1 = yi, 0 = constant 3.
- busy  out  1  high from the cycle after start is accepted until the DONE state, inclusive.
- done  out  1  one-cycle completion pulse.
- result  out  6  captured final value. Holds until the next capture or until reset.

## Operation
States are IDLE, LDX, LDY, ITER, OUT and DONE. The control outputs are Moore-decoded from the state register only.

Control decode per state:
- IDLE: all controls 0.
- LDX: sa=1, sb=1, enx=1, all others 0. The datapath loads xi = a + b.
- LDY: sa=1, sb=0, sy=0, eny=1, enx=0. The datapath loads yi = a + 3.
- ITER: sa=0, sb=0, sy=1, enx=1, eny=0. The datapath loads xi = xi + yi.
- OUT: all controls 0. dp_result = xi + 3.
- DONE: all controls 0. done=1.

Transitions:
- IDLE → LDX when start=1. In the same edge, n is latched into the iteration counter cnt.
- LDX → LDY unconditionally.
- LDY → ITER if cnt != 0, otherwise LDY → OUT.
- In ITER, cnt decrements each cycle. The FSM goes to OUT on the cycle in which cnt == 1, so ITER lasts exactly the latched n cycles.
- On the OUT → DONE edge, result <= dp_result.
- DONE → IDLE unconditionally.

Other rules:
- Arithmetic is performed in the datapath and is 6-bit modulo 64. The controller performs no arithmetic beyond the cnt decrement.
- The final value is result = (a + b + n·(a + 3) + 3) mod 64.
- Upstream must hold a and b stable through LDX and LDY. The controller does not check this.
- start in any state other than IDLE is ignored, including DONE; it is not queued.
- A change of n after acceptance has no effect on the current run.

## Timing
- Reset (RST=1 at a rising edge) forces state = IDLE, cnt = 0, result = 0, done = 0, busy = 0, and all controls = 0. Reset overrides start in the same cycle.
- Reset mid-run aborts the run immediately at that edge. No done pulse is produced and result is cleared to 0.
- Latency: if start is accepted at edge k, LDX occupies cycle k+1. done is high in cycle k+n+4, and result is valid from that cycle.
- With n = 0 the run is LDX, LDY, OUT, DONE, which is 4 cycles.
- With n = 2^CNT_W − 1 there is no counter overflow: exactly that many ITER cycles occur.
- Back-to-back runs: the earliest acceptance of the next start is at the DONE → IDLE edge + 1, that is, with start sampled in IDLE. Minimum spacing between accepts is n + 5 cycles.
- busy = (state != IDLE).

## Test plan
- Reset: assert RST for 2 cycles with start=1 → all outputs 0, state stays IDLE, no LDX.
- Nominal run: a=5, b=2, n=3, start pulse → controls sequence LDX, LDY, ITER×3, OUT; done high exactly 7 cycles after the accept edge; result=34.
- Zero iterations: a=1, b=1, n=0 → no ITER cycle (sy never 1); done 4 cycles after accept; result=5.
- Wrap-around: a=60, b=10, n=1 → xi=6, yi=63, xi=5; result=8.
- Ignored start plus n change: re-assert start and change n to 7 during ITER and during DONE → no restart; the current run completes with the original n; start held high afterwards starts a new run only from IDLE.
- Abort: assert RST during ITER of an n=5 run → all controls 0 next cycle, done never pulses, result=0; a fresh run afterwards completes correctly with the nominal values.

Source files
------------

// File: rtl/add_controller_if.sv
// add_controller_if
//   Bundles the controller's request/control/result signals.
//   slave  : seen by the controller (takes start, n, dp_result; drives the rest).
//   master : seen by the upstream/testbench side.
//   Signals: start, n[CNT_W], dp_result[6] toward the controller;
//            enx, eny, sa, sb, sy, busy, done, result[6] from the controller.
interface add_controller_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] n;
  logic [5:0]       dp_result;
  logic             enx;
  logic             eny;
  logic             sa;
  logic             sb;
  logic             sy;
  logic             busy;
  logic             done;
  logic [5:0]       result;

  modport slave (
    input  start, n, dp_result,
    output enx, eny, sa, sb, sy, busy, done, result
  );

  modport master (
    output start, n, dp_result,
    input  enx, eny, sa, sb, sy, busy, done, result
  );
endinterface

// File: rtl/add_controller.sv
// add_controller
//   Sequencing FSM for the 6-bit adder datapath. On start it runs
//   x = a + b, y = a + 3, then x += y n times, then captures x + 3 into result
//   and pulses done for one cycle.
//   Ports:
//     CLK  - clock, rising edge
//     RST  - synchronous active-high reset
//     bus  - add_controller_if.slave: start, n, dp_result in;
//            enx, eny, sa, sb, sy, busy, done, result out
//   CNT_W must match the CNT_W of the connected interface instance.
module add_controller #(
  parameter int CNT_W = 4
) (
  input logic            CLK,
  input logic            RST,
  add_controller_if.slave bus
);

  localparam int DATA_W = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDX  = 3'd1,
    LDY  = 3'd2,
    ITER = 3'd3,
    OUT  = 3'd4,
    DONE = 3'd5
  } state_t;

  typedef struct packed {
    logic enx;
    logic eny;
    logic sa;
    logic sb;
    logic sy;
    logic busy;
    logic done;
  } ctl_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] result;
  ctl_t              ctl;

  // Moore decode of a state. Outputs are registered by decoding the state
  // being entered, so they always equal decode(state) in the current cycle.
  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      LDX:  begin c.sa = 1'b1; c.sb = 1'b1; c.enx = 1'b1; c.busy = 1'b1; end
      LDY:  begin c.sa = 1'b1; c.eny = 1'b1; c.busy = 1'b1; end
      ITER: begin c.sy = 1'b1; c.enx = 1'b1; c.busy = 1'b1; end
      OUT:  c.busy = 1'b1;
      DONE: begin c.busy = 1'b1; c.done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      ctl    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LDX;
            ctl   <= decode(LDX);
            cnt   <= bus.n;
          end
        end
        LDX: begin
          state <= LDY;
          ctl   <= decode(LDY);
        end
        LDY: begin
          if (cnt != '0) begin
            state <= ITER;
            ctl   <= decode(ITER);
          end else begin
            state <= OUT;
            ctl   <= decode(OUT);
          end
        end
        ITER: begin
          // Leaving on cnt == 1 gives exactly n ITER cycles with no wrap,
          // even for n = 2^CNT_W - 1.
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= OUT;
            ctl   <= decode(OUT);
          end
        end
        OUT: begin
          result <= bus.dp_result;
          state  <= DONE;
          ctl    <= decode(DONE);
        end
        DONE: begin
          state <= IDLE;
          ctl   <= decode(IDLE);
        end
        default: begin
          state <= IDLE;
          ctl   <= '0;
        end
      endcase
    end
  end

  assign bus.enx    = ctl.enx;
  assign bus.eny    = ctl.eny;
  assign bus.sa     = ctl.sa;
  assign bus.sb     = ctl.sb;
  assign bus.sy     = ctl.sy;
  assign bus.busy   = ctl.busy;
  assign bus.done   = ctl.done;
  assign bus.result = result;

endmodule
